// File: rtl/uart_hasti_arb.sv
// Two-master arbiter in front of the UART register port: round-robin or fixed
// priority, with stall hold and a bounded mastlock run.
module uart_hasti_arb #(
  parameter int FIXED_PRIO        = 0,
  parameter int MAX_LOCK          = 8,
  parameter int HASTI_ADDR_WIDTH  = 32,
  parameter int HASTI_BUS_WIDTH   = 32,
  parameter int HASTI_SIZE_WIDTH  = 3,
  parameter int HASTI_BURST_WIDTH = 3,
  parameter int HASTI_PROT_WIDTH  = 4
) (
  input  logic                         i_clk,
  input  logic                         i_resetn,
  input  logic [HASTI_ADDR_WIDTH-1:0]  i_m0_addr,
  input  logic                         i_m0_read,
  input  logic                         i_m0_write,
  input  logic [HASTI_SIZE_WIDTH-1:0]  i_m0_size,
  input  logic [HASTI_BURST_WIDTH-1:0] i_m0_burst,
  input  logic                         i_m0_mastlock,
  input  logic [HASTI_PROT_WIDTH-1:0]  i_m0_prot,
  input  logic [HASTI_BUS_WIDTH-1:0]   i_m0_wdata,
  output logic                         o_m0_ready,
  output logic [HASTI_BUS_WIDTH-1:0]   o_m0_rdata,
  output logic                         o_m0_resp,
  input  logic [HASTI_ADDR_WIDTH-1:0]  i_m1_addr,
  input  logic                         i_m1_read,
  input  logic                         i_m1_write,
  input  logic [HASTI_SIZE_WIDTH-1:0]  i_m1_size,
  input  logic [HASTI_BURST_WIDTH-1:0] i_m1_burst,
  input  logic                         i_m1_mastlock,
  input  logic [HASTI_PROT_WIDTH-1:0]  i_m1_prot,
  input  logic [HASTI_BUS_WIDTH-1:0]   i_m1_wdata,
  output logic                         o_m1_ready,
  output logic [HASTI_BUS_WIDTH-1:0]   o_m1_rdata,
  output logic                         o_m1_resp,
  output logic [HASTI_ADDR_WIDTH-1:0]  o_s_addr,
  output logic                         o_s_read,
  output logic                         o_s_write,
  output logic [HASTI_SIZE_WIDTH-1:0]  o_s_size,
  output logic [HASTI_BURST_WIDTH-1:0] o_s_burst,
  output logic                         o_s_mastlock,
  output logic [HASTI_PROT_WIDTH-1:0]  o_s_prot,
  output logic [HASTI_BUS_WIDTH-1:0]   o_s_wdata,
  input  logic [HASTI_BUS_WIDTH-1:0]   i_s_rdata,
  input  logic                         i_s_ready,
  input  logic                         i_s_resp,
  output logic                         o_gnt,
  output logic                         o_dp_valid,
  output logic                         o_dp_owner
);
  typedef enum logic [1:0] {ST_ARB = 2'd0, ST_HOLD = 2'd1, ST_LOCK = 2'd2} state_t;
  localparam logic [7:0] LOCK_MAX = 8'(MAX_LOCK);

  state_t     r_state;
  logic       r_gnt, r_last, r_force, r_idle, r_dp_valid, r_dp_owner;
  logic [7:0] r_lock_cnt;
  logic       w_req0, w_req1, w_gnt, w_owner_req, w_acc, w_lock;
  logic [7:0] w_cnt_nxt;

  assign w_req0 = i_m0_read | i_m0_write;
  assign w_req1 = i_m1_read | i_m1_write;

  // Only ARB re-arbitrates; HOLD and LOCK keep the registered owner.
  // r_force hands the tie to the other master right after a lock expiry.
  always_comb begin
    w_gnt = r_gnt;
    if (r_state == ST_ARB) begin
      if (w_req0 && w_req1) w_gnt = (FIXED_PRIO != 0 && !r_force) ? 1'b0 : ~r_last;
      else if (w_req0)      w_gnt = 1'b0;
      else if (w_req1)      w_gnt = 1'b1;
    end
  end

  assign w_owner_req = w_gnt ? w_req1 : w_req0;
  assign w_acc       = w_owner_req & i_s_ready;
  assign w_lock      = w_gnt ? i_m1_mastlock : i_m0_mastlock;
  assign w_cnt_nxt   = r_lock_cnt + 8'd1;

  assign o_m0_ready   = ~w_gnt & w_req0 & i_s_ready;
  assign o_m1_ready   =  w_gnt & w_req1 & i_s_ready;
  assign o_s_addr     = w_gnt ? i_m1_addr     : i_m0_addr;
  assign o_s_read     = w_gnt ? i_m1_read     : i_m0_read;
  assign o_s_write    = w_gnt ? i_m1_write    : i_m0_write;
  assign o_s_size     = w_gnt ? i_m1_size     : i_m0_size;
  assign o_s_burst    = w_gnt ? i_m1_burst    : i_m0_burst;
  assign o_s_mastlock = w_gnt ? i_m1_mastlock : i_m0_mastlock;
  assign o_s_prot     = w_gnt ? i_m1_prot     : i_m0_prot;
  assign o_s_wdata    = w_gnt ? i_m1_wdata    : i_m0_wdata;

  assign o_m0_rdata = (r_dp_valid && !r_dp_owner) ? i_s_rdata : '0;
  assign o_m1_rdata = (r_dp_valid &&  r_dp_owner) ? i_s_rdata : '0;
  assign o_m0_resp  = r_dp_valid & ~r_dp_owner & i_s_resp;
  assign o_m1_resp  = r_dp_valid &  r_dp_owner & i_s_resp;
  assign o_gnt      = w_gnt;
  assign o_dp_valid = r_dp_valid;
  assign o_dp_owner = r_dp_owner;

  always_ff @(posedge i_clk) begin
    if (!i_resetn) begin
      r_state    <= ST_ARB;
      r_gnt      <= 1'b0;
      r_last     <= 1'b1;
      r_force    <= 1'b0;
      r_idle     <= 1'b0;
      r_lock_cnt <= 8'd0;
      r_dp_valid <= 1'b0;
      r_dp_owner <= 1'b0;
    end else begin
      r_gnt      <= w_gnt;
      r_dp_valid <= w_acc;
      if (w_acc) begin
        r_last     <= w_gnt;
        r_dp_owner <= w_gnt;
      end
      case (r_state)
        ST_ARB, ST_HOLD: begin
          r_idle <= 1'b0;
          if (w_acc) begin
            r_force <= 1'b0;
            if (w_lock && LOCK_MAX > 8'd1) begin
              r_state    <= ST_LOCK;
              r_lock_cnt <= 8'd1;
            end else begin
              r_state <= ST_ARB;
            end
          end else if (w_owner_req) begin
            r_state <= ST_HOLD;
          end else begin
            r_state <= ST_ARB;
          end
        end
        ST_LOCK: begin
          if (w_acc) begin
            r_idle <= 1'b0;
            if (!w_lock) begin
              r_state    <= ST_ARB;
              r_lock_cnt <= 8'd0;
            end else if (w_cnt_nxt >= LOCK_MAX) begin
              r_state    <= ST_ARB;
              r_lock_cnt <= 8'd0;
              r_force    <= 1'b1;
            end else begin
              r_lock_cnt <= w_cnt_nxt;
            end
          end else if (!w_owner_req) begin
            // Two idle cycles from the lock owner release the lock.
            if (r_idle) begin
              r_state    <= ST_ARB;
              r_lock_cnt <= 8'd0;
              r_idle     <= 1'b0;
            end else begin
              r_idle <= 1'b1;
            end
          end else begin
            r_idle <= 1'b0;
          end
        end
        default: r_state <= ST_ARB;
      endcase
    end
  end
endmodule

// File: tb/tb_uart_hasti_arb.sv
// Scoreboard bench for uart_hasti_arb: expected acceptances are queued by the
// stimulus and matched by a negedge monitor, plus data-phase routing checks.
module tb_uart_hasti_arb;
  typedef struct packed {
    logic        m;
    logic [31:0] addr;
    logic        wr;
    logic        lock;
    logic [31:0] wdata;
    logic [31:0] rd;
    logic        rs;
  } exp_t;

  logic        clk = 1'b0;
  logic        resetn;
  logic [31:0] m0_addr, m1_addr, m0_wdata, m1_wdata, s_rdata;
  logic        m0_read, m0_write, m0_lock, m1_read, m1_write, m1_lock;
  logic        fp_m0_read, fp_m1_read, s_ready, s_resp;
  logic [2:0]  m0_size = 3'd2, m1_size = 3'd0, m0_burst = 3'd0, m1_burst = 3'd1;
  logic [3:0]  m0_prot = 4'd1, m1_prot = 4'd2;
  logic        zero = 1'b0;

  logic        m0_ready, m1_ready, m0_resp, m1_resp, gnt, dp_valid, dp_owner;
  logic        s_read, s_write, s_lock;
  logic [31:0] m0_rdata, m1_rdata, s_addr, s_wdata;
  logic [2:0]  s_size, s_burst;
  logic [3:0]  s_prot;

  logic        f_m0_ready, f_m1_ready, f_m0_resp, f_m1_resp, f_gnt, f_dpv, f_dpo;
  logic        f_s_read, f_s_write, f_s_lock;
  logic [31:0] f_m0_rdata, f_m1_rdata, f_s_addr, f_s_wdata;
  logic [2:0]  f_s_size, f_s_burst;
  logic [3:0]  f_s_prot;

  int total = 0;
  int bad   = 0;
  exp_t        q[$];
  logic        fq[$];
  string       ck_nm[$];
  logic [31:0] ck_act[$], ck_exp[$];
  logic        pend_v = 1'b0, pend_m = 1'b0, pend_rs = 1'b0;
  logic [31:0] pend_rd = '0;

  uart_hasti_arb #(.FIXED_PRIO(0), .MAX_LOCK(3)) dut (
    .i_clk(clk), .i_resetn(resetn),
    .i_m0_addr(m0_addr), .i_m0_read(m0_read), .i_m0_write(m0_write), .i_m0_size(m0_size),
    .i_m0_burst(m0_burst), .i_m0_mastlock(m0_lock), .i_m0_prot(m0_prot), .i_m0_wdata(m0_wdata),
    .o_m0_ready(m0_ready), .o_m0_rdata(m0_rdata), .o_m0_resp(m0_resp),
    .i_m1_addr(m1_addr), .i_m1_read(m1_read), .i_m1_write(m1_write), .i_m1_size(m1_size),
    .i_m1_burst(m1_burst), .i_m1_mastlock(m1_lock), .i_m1_prot(m1_prot), .i_m1_wdata(m1_wdata),
    .o_m1_ready(m1_ready), .o_m1_rdata(m1_rdata), .o_m1_resp(m1_resp),
    .o_s_addr(s_addr), .o_s_read(s_read), .o_s_write(s_write), .o_s_size(s_size),
    .o_s_burst(s_burst), .o_s_mastlock(s_lock), .o_s_prot(s_prot), .o_s_wdata(s_wdata),
    .i_s_rdata(s_rdata), .i_s_ready(s_ready), .i_s_resp(s_resp),
    .o_gnt(gnt), .o_dp_valid(dp_valid), .o_dp_owner(dp_owner)
  );

  uart_hasti_arb #(.FIXED_PRIO(1), .MAX_LOCK(8)) dut_fp (
    .i_clk(clk), .i_resetn(resetn),
    .i_m0_addr(m0_addr), .i_m0_read(fp_m0_read), .i_m0_write(zero), .i_m0_size(m0_size),
    .i_m0_burst(m0_burst), .i_m0_mastlock(zero), .i_m0_prot(m0_prot), .i_m0_wdata(m0_wdata),
    .o_m0_ready(f_m0_ready), .o_m0_rdata(f_m0_rdata), .o_m0_resp(f_m0_resp),
    .i_m1_addr(m1_addr), .i_m1_read(fp_m1_read), .i_m1_write(zero), .i_m1_size(m1_size),
    .i_m1_burst(m1_burst), .i_m1_mastlock(zero), .i_m1_prot(m1_prot), .i_m1_wdata(m1_wdata),
    .o_m1_ready(f_m1_ready), .o_m1_rdata(f_m1_rdata), .o_m1_resp(f_m1_resp),
    .o_s_addr(f_s_addr), .o_s_read(f_s_read), .o_s_write(f_s_write), .o_s_size(f_s_size),
    .o_s_burst(f_s_burst), .o_s_mastlock(f_s_lock), .o_s_prot(f_s_prot), .o_s_wdata(f_s_wdata),
    .i_s_rdata(s_rdata), .i_s_ready(s_ready), .i_s_resp(s_resp),
    .o_gnt(f_gnt), .o_dp_valid(f_dpv), .o_dp_owner(f_dpo)
  );

  always #5 clk = ~clk;

  task automatic cmp(input string nm, input logic [31:0] a, input logic [31:0] e);
    total++;
    if (a !== e) begin
      bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", nm, a, e, $time);
    end
  endtask

  task automatic mon_step();
    exp_t e;
    while (ck_nm.size() > 0) cmp(ck_nm.pop_front(), ck_act.pop_front(), ck_exp.pop_front());
    if (!resetn) begin
      pend_v <= 1'b0;
    end else begin
      cmp("dp_valid", 32'(dp_valid), 32'(pend_v));
      if (pend_v) begin
        cmp("dp_owner", 32'(dp_owner), 32'(pend_m));
        cmp("owner_rdata", pend_m ? m1_rdata : m0_rdata, pend_rd);
        cmp("owner_resp", 32'(pend_m ? m1_resp : m0_resp), 32'(pend_rs));
        cmp("other_rdata", pend_m ? m0_rdata : m1_rdata, 32'h0);
        cmp("other_resp", 32'(pend_m ? m0_resp : m1_resp), 32'h0);
      end
      if (m0_ready && m1_ready) cmp("both_ready", 32'd1, 32'd0);
      pend_v <= 1'b0;
      if (m0_ready || m1_ready) begin
        if (q.size() == 0) begin
          cmp("unexpected_accept", 32'(m1_ready), 32'hFFFF_FFFF);
        end else begin
          e = q.pop_front();
          cmp("acc_master", 32'(m1_ready), 32'(e.m));
          cmp("s_addr", s_addr, e.addr);
          cmp("s_write", 32'(s_write), 32'(e.wr));
          cmp("s_read", 32'(s_read), 32'(!e.wr));
          cmp("s_mastlock", 32'(s_lock), 32'(e.lock));
          cmp("s_prot", 32'(s_prot), e.m ? 32'd2 : 32'd1);
          cmp("s_size", 32'(s_size), e.m ? 32'd0 : 32'd2);
          if (e.wr) cmp("s_wdata", s_wdata, e.wdata);
          pend_v  <= 1'b1;
          pend_m  <= e.m;
          pend_rd <= e.rd;
          pend_rs <= e.rs;
        end
      end
      if (f_m0_ready && f_m1_ready) cmp("fp_both_ready", 32'd1, 32'd0);
      if (f_m0_ready || f_m1_ready) begin
        if (fq.size() == 0) cmp("fp_unexpected_accept", 32'(f_m1_ready), 32'hFFFF_FFFF);
        else cmp("fp_acc_master", 32'(f_m1_ready), 32'(fq.pop_front()));
      end
    end
  endtask

  always @(negedge clk) mon_step();

  task automatic ck(input string nm, input logic [31:0] a, input logic [31:0] e);
    ck_nm.push_back(nm);
    ck_act.push_back(a);
    ck_exp.push_back(e);
  endtask

  task automatic push(input logic m, input logic [31:0] addr, input logic wr, input logic lock,
                      input logic [31:0] wdata, input logic [31:0] rd, input logic rs);
    exp_t e;
    e = '{m: m, addr: addr, wr: wr, lock: lock, wdata: wdata, rd: rd, rs: rs};
    q.push_back(e);
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_all();
    m0_read = 0; m0_write = 0; m0_lock = 0;
    m1_read = 0; m1_write = 0; m1_lock = 0;
    fp_m0_read = 0; fp_m1_read = 0;
  endtask

  task automatic do_reset();
    resetn = 1'b0;
    cyc();
    cyc();
    resetn = 1'b1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    idle_all();
    m0_addr = 0; m1_addr = 0; m0_wdata = 0; m1_wdata = 0;
    s_rdata = 0; s_ready = 1; s_resp = 0;
    do_reset();
    #1;
    ck("rst_state", 32'(dut.r_state), 32'd0);
    ck("rst_gnt", 32'(gnt), 32'd0);
    ck("rst_last", 32'(dut.r_last), 32'd1);
    ck("rst_lock_cnt", 32'(dut.r_lock_cnt), 32'd0);
    ck("rst_dp_valid", 32'(dp_valid), 32'd0);
    ck("rst_dp_owner", 32'(dp_owner), 32'd0);
    ck("rst_m0_rdata", m0_rdata, 32'd0);
    ck("rst_m1_resp", 32'(m1_resp), 32'd0);
    cyc();

    // Solo read from m0, error response routed only to m0
    s_rdata = 32'h1; s_resp = 1;
    push(0, 32'h4, 0, 0, 0, 32'h1, 1);
    m0_addr = 32'h4; m0_read = 1;
    cyc();
    idle_all();
    cyc();
    s_resp = 0;

    // Continuous tie: round-robin 0,1,0,1 and fixed-priority 0,0,0,0
    do_reset();
    s_rdata = 32'h22;
    m0_addr = 32'h8; m1_addr = 32'h10;
    push(0, 32'h8, 0, 0, 0, 32'h22, 0); push(1, 32'h10, 0, 0, 0, 32'h22, 0);
    push(0, 32'h8, 0, 0, 0, 32'h22, 0); push(1, 32'h10, 0, 0, 0, 32'h22, 0);
    for (int i = 0; i < 4; i++) fq.push_back(1'b0);
    m0_read = 1; m1_read = 1; fp_m0_read = 1; fp_m1_read = 1;
    repeat (4) cyc();
    idle_all();
    cyc();

    // Stall: m1 write held in HOLD, m0 waits behind it
    s_rdata = 32'h33; s_ready = 0;
    m1_addr = 32'hC; m1_wdata = 32'h41; m1_write = 1;
    push(1, 32'hC, 1, 0, 32'h41, 32'h33, 0);
    push(0, 32'h8, 0, 0, 0, 32'h33, 0);
    cyc();
    m0_read = 1;
    for (int i = 0; i < 2; i++) begin
      #1;
      ck("hold_state", 32'(dut.r_state), 32'd1);
      ck("hold_gnt", 32'(gnt), 32'd1);
      ck("hold_s_addr", s_addr, 32'hC);
      ck("hold_s_wdata", s_wdata, 32'h41);
      ck("hold_m1_ready", 32'(m1_ready), 32'd0);
      ck("hold_m0_ready", 32'(m0_ready), 32'd0);
      cyc();
    end
    s_ready = 1;
    cyc();
    m1_write = 0;
    cyc();
    idle_all();
    cyc();

    // Lock limit of 3, then m1 takes the next tie
    s_rdata = 32'h44;
    m0_addr = 32'h14; m1_addr = 32'h18;
    for (int i = 0; i < 3; i++) push(0, 32'h14, 0, 1, 0, 32'h44, 0);
    push(1, 32'h18, 0, 0, 0, 32'h44, 0);
    m0_read = 1; m0_lock = 1;
    cyc();
    m1_read = 1;
    #1;
    ck("lock_state", 32'(dut.r_state), 32'd2);
    ck("lock_cnt1", 32'(dut.r_lock_cnt), 32'd1);
    cyc();
    ck("lock_cnt2", 32'(dut.r_lock_cnt), 32'd2);
    cyc();
    ck("expire_state", 32'(dut.r_state), 32'd0);
    ck("expire_cnt", 32'(dut.r_lock_cnt), 32'd0);
    cyc();
    idle_all();
    cyc();

    // Lock release by an unlocked transfer while m1 waits
    s_rdata = 32'h55;
    m0_addr = 32'h4; m0_wdata = 32'h99; m0_write = 1; m0_lock = 1;
    m1_addr = 32'h8; m1_read = 1;
    push(0, 32'h4, 1, 1, 32'h99, 32'h55, 0);
    push(0, 32'h0, 0, 0, 0, 32'h55, 0);
    push(1, 32'h8, 0, 0, 0, 32'h55, 0);
    cyc();
    ck("rel_state_lock", 32'(dut.r_state), 32'd2);
    m0_write = 0; m0_lock = 0; m0_read = 1; m0_addr = 32'h0;
    cyc();
    ck("rel_state_arb", 32'(dut.r_state), 32'd0);
    m0_read = 0;
    cyc();
    idle_all();
    cyc();

    // Reset while locked discards the in-flight transfer
    s_rdata = 32'h66;
    m0_addr = 32'h4; m0_read = 1; m0_lock = 1;
    push(0, 32'h4, 0, 1, 0, 32'h66, 0);
    cyc();
    ck("prerst_state", 32'(dut.r_state), 32'd2);
    ck("prerst_cnt", 32'(dut.r_lock_cnt), 32'd1);
    resetn = 0;
    cyc();
    resetn = 1;
    idle_all();
    #1;
    ck("midrst_state", 32'(dut.r_state), 32'd0);
    ck("midrst_gnt", 32'(gnt), 32'd0);
    ck("midrst_dp_valid", 32'(dp_valid), 32'd0);
    ck("midrst_cnt", 32'(dut.r_lock_cnt), 32'd0);
    cyc();

    ck("sb_left", 32'(q.size()), 32'd0);
    ck("fp_sb_left", 32'(fq.size()), 32'd0);
    cyc();
    cyc();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
